// File: rtl/llsc_monitor.sv
// LL/SC reservation monitor: one granule-sized reservation, SC success decision, llbit write port.
// Define LLSC_SNOOP_EN to let external bus writes (snoop_we/snoop_addr) cancel the reservation.
module llsc_monitor #(
  parameter int ADDR_W    = 32,
  parameter int GRAN_LSB  = 2,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              ll_req,
  input  logic              sc_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              sc_ok,
  output logic              llbit_we,
  output logic              llbit_wdata,
  output logic              resv_valid,
  output logic [ADDR_W-1:0] resv_addr
);

  localparam int GW = ADDR_W - GRAN_LSB;
  localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic {IDLE = 1'b0, RESV = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        resv_gran_q, resv_gran_d;
  logic [TIMEOUT_W-1:0] age_q, age_d;
  logic                 llbit_we_q, llbit_we_d;
  logic                 llbit_wdata_q, llbit_wdata_d;

  logic [GW-1:0] mem_gran;
  logic          ll, sc, st, resv, hit_m, hit_s, ll_snoop_hit;
  logic          ll_open, reopen;
  logic          unused_low_bits;

  assign mem_gran = mem_addr[ADDR_W-1:GRAN_LSB];
  assign ll       = ll_req & ~stall;
  assign sc       = sc_req & ~stall;
  assign st       = st_req & ~stall;
  assign resv     = (state_q == RESV);
  assign hit_m    = (mem_gran == resv_gran_q);

`ifdef LLSC_SNOOP_EN
  assign hit_s        = snoop_we & (snoop_addr[ADDR_W-1:GRAN_LSB] == resv_gran_q);
  assign ll_snoop_hit = snoop_we & (snoop_addr[ADDR_W-1:GRAN_LSB] == mem_gran);
  assign unused_low_bits = ^{mem_addr[GRAN_LSB-1:0], snoop_addr[GRAN_LSB-1:0]};
`else
  assign hit_s        = 1'b0;
  assign ll_snoop_hit = 1'b0;
  assign unused_low_bits = ^{mem_addr[GRAN_LSB-1:0], snoop_we, snoop_addr};
`endif

  // SC needs the reservation to survive this very cycle, hence the flush/snoop masks.
  assign sc_ok = sc & resv & hit_m & ~flush & ~hit_s;

  always_comb begin
    state_d     = state_q;
    resv_gran_d = resv_gran_q;
    ll_open     = 1'b0;
    reopen      = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else if (resv && (hit_s || sc || (st && hit_m) || (TMO_EN && age_q == TMO))) begin
      state_d = IDLE;
    end else if (ll) begin
      if (ll_snoop_hit) begin
        state_d = IDLE;
      end else begin
        state_d     = RESV;
        resv_gran_d = mem_gran;
        ll_open     = 1'b1;
        reopen      = resv;
      end
    end

    age_d = age_q;
    if (state_d == IDLE || ll_open) begin
      age_d = '0;
    end else if (age_q != TMO) begin
      age_d = age_q + TIMEOUT_W'(1);
    end

    // A re-opening LL leaves resv_valid at 1 but still refreshes the llbit.
    llbit_we_d    = (state_d != state_q) | reopen;
    llbit_wdata_d = llbit_we_d ? (state_d == RESV) : llbit_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      resv_gran_q   <= '0;
      age_q         <= '0;
      llbit_we_q    <= 1'b0;
      llbit_wdata_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      resv_gran_q   <= resv_gran_d;
      age_q         <= age_d;
      llbit_we_q    <= llbit_we_d;
      llbit_wdata_q <= llbit_wdata_d;
    end
  end

  assign resv_valid  = resv;
  assign resv_addr   = {resv_gran_q, {GRAN_LSB{1'b0}}};
  assign llbit_we    = llbit_we_q;
  assign llbit_wdata = llbit_wdata_q;

endmodule

// File: tb/tb_llsc_monitor.sv
// Bench for llsc_monitor: three instances (TIMEOUT 255 / 4 / 0) on shared stimulus,
// directed scenarios plus random traffic checked against a cycle-count reservation model.
module tb_llsc_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, stall, ll_req, sc_req, st_req, snoop_we;
  logic [31:0] mem_addr, snoop_addr;

  logic        sc_ok_o       [3];
  logic        llbit_we_o    [3];
  logic        llbit_wdata_o [3];
  logic        resv_valid_o  [3];
  logic [31:0] resv_addr_o   [3];

`ifdef LLSC_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state per instance.
  int          tmo  [3] = '{255, 4, 0};
  bit          mv   [3];
  logic [31:0] ma   [3];
  int          mage [3];
  bit          mwe  [3];
  bit          mwd  [3];
  bit          exp_sc [3];
  bit          obs_sc [3];

  always #5 clk = ~clk;

  llsc_monitor #(.TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .ll_req(ll_req), .sc_req(sc_req),
    .st_req(st_req), .mem_addr(mem_addr), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .sc_ok(sc_ok_o[0]), .llbit_we(llbit_we_o[0]), .llbit_wdata(llbit_wdata_o[0]),
    .resv_valid(resv_valid_o[0]), .resv_addr(resv_addr_o[0]));

  llsc_monitor #(.TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .ll_req(ll_req), .sc_req(sc_req),
    .st_req(st_req), .mem_addr(mem_addr), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .sc_ok(sc_ok_o[1]), .llbit_we(llbit_we_o[1]), .llbit_wdata(llbit_wdata_o[1]),
    .resv_valid(resv_valid_o[1]), .resv_addr(resv_addr_o[1]));

  llsc_monitor #(.TIMEOUT(0)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .ll_req(ll_req), .sc_req(sc_req),
    .st_req(st_req), .mem_addr(mem_addr), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .sc_ok(sc_ok_o[2]), .llbit_we(llbit_we_o[2]), .llbit_wdata(llbit_wdata_o[2]),
    .resv_valid(resv_valid_o[2]), .resv_addr(resv_addr_o[2]));

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; ma[k] = '0; mage[k] = 0; mwe[k] = 1'b0; mwd[k] = 1'b0;
    end
  endtask

  task automatic drive(input bit l, input bit s, input bit w, input bit stl, input bit fl,
                       input logic [31:0] a, input bit swe, input logic [31:0] sa);
    ll_req = l; sc_req = s; st_req = w; stall = stl; flush = fl;
    mem_addr = a; snoop_we = swe; snoop_addr = sa;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // One clock: sample sc_ok before the edge, then advance the model with the same inputs.
  task automatic tick();
    bit l, s, w, hm, hs, nv, reo;
    @(negedge clk);
    l = ll_req && !stall;
    s = sc_req && !stall;
    w = st_req && !stall;
    for (int k = 0; k < 3; k++) begin
      hm = (mem_addr >> 2) == (ma[k] >> 2);
      hs = SNOOP && snoop_we && ((snoop_addr >> 2) == (ma[k] >> 2));
      obs_sc[k] = sc_ok_o[k];
      exp_sc[k] = s && mv[k] && hm && !flush && !hs;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      hm  = (mem_addr >> 2) == (ma[k] >> 2);
      hs  = SNOOP && snoop_we && ((snoop_addr >> 2) == (ma[k] >> 2));
      reo = 1'b0;
      if (flush) nv = 1'b0;
      else if (mv[k] && (hs || s || (w && hm) || (tmo[k] != 0 && mage[k] == tmo[k]))) nv = 1'b0;
      else if (l) begin
        if (SNOOP && snoop_we && ((snoop_addr >> 2) == (mem_addr >> 2))) nv = 1'b0;
        else begin
          nv = 1'b1; reo = mv[k]; ma[k] = mem_addr & ~32'h3; mage[k] = 0;
        end
      end else begin
        nv = mv[k];
        if (mv[k]) mage[k]++;
      end
      mwe[k] = (nv != mv[k]) || reo;
      if (mwe[k]) mwd[k] = nv;
      mv[k] = nv;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (resv_valid_o[k] !== 1'b0 || resv_addr_o[k] !== 32'h0 || llbit_we_o[k] !== 1'b0 ||
          llbit_wdata_o[k] !== 1'b0 || sc_ok_o[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got valid=%b addr=%h we=%b wd=%b sc_ok=%b, want all 0",
                 k, resv_valid_o[k], resv_addr_o[k], llbit_we_o[k], llbit_wdata_o[k], sc_ok_o[k]);
      end
    end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_ll_sc();
    drive(1, 0, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    tests_run++;
    if (llbit_we_o[0] !== 1'b1 || llbit_wdata_o[0] !== 1'b1 || resv_addr_o[0] !== 32'h100) begin
      tests_failed++;
      $display("FAIL ll_open: got we=%b wd=%b addr=%h, want 1 1 00000100",
               llbit_we_o[0], llbit_wdata_o[0], resv_addr_o[0]);
    end
    idle(); repeat (3) tick();
    drive(0, 1, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== 1'b1) begin
      tests_failed++; $display("FAIL ll_sc_ok: got %b want 1", obs_sc[0]);
    end
    tests_run++;
    if (llbit_we_o[0] !== 1'b1 || llbit_wdata_o[0] !== 1'b0 || resv_valid_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sc_close: got we=%b wd=%b valid=%b, want 1 0 0",
               llbit_we_o[0], llbit_wdata_o[0], resv_valid_o[0]);
    end
    idle(); tick();
    $display("[TB] ll/sc basic done");
  endtask

  task automatic test_store();
    drive(1, 0, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    drive(0, 0, 1, 0, 0, 32'h102, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== 1'b0) begin
      tests_failed++; $display("FAIL store_same_granule: sc_ok got %b want 0", obs_sc[0]);
    end
    drive(1, 0, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    drive(0, 0, 1, 0, 0, 32'h104, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== 1'b1) begin
      tests_failed++; $display("FAIL store_other_granule: sc_ok got %b want 1", obs_sc[0]);
    end
    idle(); tick();
    $display("[TB] store cancel done");
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 32'h200, 0, 32'h0); tick();
    idle();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i < 6) begin
        tests_run++;
        if (llbit_we_o[1] !== (i == 4) || (i == 4 && llbit_wdata_o[1] !== 1'b0)) begin
          tests_failed++;
          $display("FAIL timeout4_llbit idle %0d: got we=%b wd=%b, want we=%b wd=0",
                   i, llbit_we_o[1], llbit_wdata_o[1], i == 4);
        end
      end
    end
    drive(0, 1, 0, 0, 0, 32'h200, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[1] !== 1'b0 || obs_sc[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sc: got t4=%b t0=%b, want 0 1", obs_sc[1], obs_sc[2]);
    end
    idle(); tick();
    $display("[TB] timeout done");
  endtask

  task automatic test_flush_stall();
    drive(1, 0, 0, 0, 0, 32'h300, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 1, 32'h300, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== 1'b0 || resv_valid_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_sc: got sc_ok=%b valid=%b want 0 0", obs_sc[0], resv_valid_o[0]);
    end
    drive(1, 0, 0, 0, 0, 32'h300, 0, 32'h0); tick();
    drive(0, 1, 0, 1, 0, 32'h300, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== 1'b0 || resv_valid_o[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_sc: got sc_ok=%b valid=%b want 0 1", obs_sc[0], resv_valid_o[0]);
    end
    drive(0, 1, 0, 0, 0, 32'h300, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== 1'b1) begin
      tests_failed++; $display("FAIL sc_after_stall: got %b want 1", obs_sc[0]);
    end
    idle(); tick();
    $display("[TB] flush/stall done");
  endtask

  task automatic test_snoop();
    drive(1, 0, 0, 0, 0, 32'h400, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 0, 32'h0, 1, 32'h400); tick();
    tests_run++;
    if (resv_valid_o[0] !== !SNOOP) begin
      tests_failed++; $display("FAIL snoop_cancel: valid got %b want %b", resv_valid_o[0], !SNOOP);
    end
    drive(0, 1, 0, 0, 0, 32'h400, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== !SNOOP) begin
      tests_failed++; $display("FAIL snoop_sc: got %b want %b", obs_sc[0], !SNOOP);
    end
    drive(1, 0, 0, 0, 0, 32'h400, 1, 32'h400); tick();
    tests_run++;
    if (resv_valid_o[0] !== !SNOOP) begin
      tests_failed++; $display("FAIL snoop_with_ll: valid got %b want %b", resv_valid_o[0], !SNOOP);
    end
    drive(0, 1, 0, 0, 0, 32'h400, 0, 32'h0); tick();
    tests_run++;
    if (obs_sc[0] !== !SNOOP) begin
      tests_failed++; $display("FAIL snoop_with_ll_sc: got %b want %b", obs_sc[0], !SNOOP);
    end
    idle(); tick();
    $display("[TB] snoop done (enabled=%0d)", SNOOP);
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 32'h100, 0, 32'h0); tick();
    idle();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (resv_valid_o[k] !== 1'b0 || resv_addr_o[k] !== 32'h0 ||
          llbit_we_o[k] !== 1'b0 || llbit_wdata_o[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL async_reset[%0d]: got valid=%b addr=%h we=%b wd=%b, want all 0",
                 k, resv_valid_o[k], resv_addr_o[k], llbit_we_o[k], llbit_wdata_o[k]);
      end
    end
    rst = 1'b0;
    model_reset();
    tick();
    $display("[TB] async reset done");
  endtask

  task automatic test_random();
    logic [31:0] a, sa;
    for (int n = 0; n < 3000; n++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'h200 : 32'h100 + 32'($urandom_range(0, 15));
      sa = 32'h100 + 32'($urandom_range(0, 15));
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3, a,
            $urandom_range(0, 99) < 10, sa);
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_sc[k] !== exp_sc[k]) begin
          tests_failed++;
          $display("FAIL rand_sc_ok[%0d] cyc %0d: got %b want %b", k, n, obs_sc[k], exp_sc[k]);
        end
        tests_run++;
        if (resv_valid_o[k] !== mv[k] || llbit_we_o[k] !== mwe[k] ||
            (mwe[k] && llbit_wdata_o[k] !== mwd[k]) || (mv[k] && resv_addr_o[k] !== ma[k])) begin
          tests_failed++;
          $display("FAIL rand_state[%0d] cyc %0d: got valid=%b we=%b wd=%b addr=%h want %b %b %b %h",
                   k, n, resv_valid_o[k], llbit_we_o[k], llbit_wdata_o[k], resv_addr_o[k],
                   mv[k], mwe[k], mwd[k], ma[k]);
        end
      end
    end
    idle(); tick();
    $display("[TB] random traffic done");
  endtask

  initial begin
    test_reset();
    test_ll_sc();
    test_store();
    test_timeout();
    test_flush_stall();
    test_snoop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
